// File: rtl/clk_div_pkg.sv
// Shared types and defaults for the multi-channel programmable clock/strobe divider.
package clk_div_pkg;

  typedef enum logic {MODE_SQUARE = 1'b0, MODE_STROBE = 1'b1} div_mode_t;

  localparam int CNT_W_DEF = 16;
  localparam logic [15:0] DEFAULT_DIV_DEF = 16'd49;

  // Channel-select width; a single channel still needs a one-bit select port.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/div_chan.sv
// One divider channel: counter, double-buffered divisor and registered
// square-clock / tick-strobe outputs.
module div_chan
  import clk_div_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter logic [CNT_W-1:0] DEFAULT_DIV = CNT_W'(DEFAULT_DIV_DEF)
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic             sync,
  input  logic             wr,
  input  logic [CNT_W-1:0] wdata,
  output logic             clk_out,
  output logic             tick,
  output logic             pending
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] active_div;
  logic [CNT_W-1:0] shadow;
  logic             wrap;
  div_mode_t        cur_mode;

  assign cur_mode = div_mode_t'(mode);
  assign wrap     = en && (cnt == active_div);

  // Divisor only changes at a wrap or while disabled, so cnt never passes active_div.
  always_ff @(posedge clk_in) begin
    if (!rst) begin
      cnt        <= '0;
      active_div <= DEFAULT_DIV;
      shadow     <= '0;
      pending    <= 1'b0;
      clk_out    <= 1'b0;
      tick       <= 1'b0;
    end else if (sync) begin
      cnt     <= '0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
      if (wr) begin
        shadow  <= wdata;
        pending <= 1'b1;
      end
    end else if (!en) begin
      cnt     <= '0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
      if (wr) begin
        active_div <= wdata;
        shadow     <= wdata;
        pending    <= 1'b0;
      end else if (pending) begin
        active_div <= shadow;
        pending    <= 1'b0;
      end
    end else begin
      cnt <= wrap ? '0 : cnt + CNT_W'(1);
      if (wrap) begin
        if (wr) begin
          active_div <= wdata;
          shadow     <= wdata;
          pending    <= 1'b0;
        end else if (pending) begin
          active_div <= shadow;
          pending    <= 1'b0;
        end
      end else if (wr) begin
        shadow  <= wdata;
        pending <= 1'b1;
      end
      if (cur_mode == MODE_STROBE) begin
        tick    <= wrap;
        clk_out <= 1'b0;
      end else begin
        tick    <= 1'b0;
        clk_out <= clk_out ^ wrap;
      end
    end
  end

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable divider: one div_chan per channel plus the
// divisor-write address decode.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int N_CH = 2,
  parameter int CNT_W = CNT_W_DEF,
  parameter logic [CNT_W-1:0] DEFAULT_DIV = CNT_W'(DEFAULT_DIV_DEF),
  localparam int SEL_W = sel_width(N_CH)
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic [N_CH-1:0]  en,
  input  logic [N_CH-1:0]  mode,
  input  logic             sync,
  input  logic             div_wr,
  input  logic [SEL_W-1:0] div_sel,
  input  logic [CNT_W-1:0] div_wdata,
  output logic [N_CH-1:0]  clk_out,
  output logic [N_CH-1:0]  tick,
  output logic [N_CH-1:0]  pending
);

  // Out-of-range selects match no channel and are silently dropped.
  for (genvar i = 0; i < N_CH; i++) begin : g_chan
    logic wr_ch;

    assign wr_ch = div_wr && (div_sel == SEL_W'(i));

    div_chan #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_chan (
      .clk_in  (clk_in),
      .rst     (rst),
      .en      (en[i]),
      .mode    (mode[i]),
      .sync    (sync),
      .wr      (wr_ch),
      .wdata   (div_wdata),
      .clk_out (clk_out[i]),
      .tick    (tick[i]),
      .pending (pending[i])
    );
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Self-checking bench for clk_div_multi: directed timing checks with literal
// expectations plus randomized traffic compared against a behavioural model.
module tb_clk_div_multi;
  localparam int N_CH  = 3;
  localparam int CNT_W = 16;
  localparam int SEL_W = 2;

  logic             clk_in = 1'b0;
  logic             rst = 1'b0;
  logic [N_CH-1:0]  en = '0;
  logic [N_CH-1:0]  mode = '0;
  logic             sync = 1'b0;
  logic             div_wr = 1'b0;
  logic [SEL_W-1:0] div_sel = '0;
  logic [CNT_W-1:0] div_wdata = '0;
  logic [N_CH-1:0]  clk_out, tick, pending;

  int checks = 0;
  int errors = 0;

  clk_div_multi #(.N_CH(N_CH), .CNT_W(CNT_W), .DEFAULT_DIV(16'd49)) dut (
    .clk_in(clk_in), .rst(rst), .en(en), .mode(mode), .sync(sync),
    .div_wr(div_wr), .div_sel(div_sel), .div_wdata(div_wdata),
    .clk_out(clk_out), .tick(tick), .pending(pending)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: each channel tracks cycles elapsed in its current period.
  int m_act[N_CH], m_sh[N_CH], m_el[N_CH];
  bit m_pend[N_CH], m_sq[N_CH], m_tk[N_CH];
  bit model_ok = 1'b0;

  always @(posedge clk_in) begin
    for (int c = 0; c < N_CH; c++) begin
      bit w, fin;
      w = div_wr && (int'(div_sel) == c);
      if (!rst) begin
        m_el[c] = 0; m_act[c] = 49; m_sh[c] = 0; m_pend[c] = 0; m_sq[c] = 0; m_tk[c] = 0;
      end else if (sync) begin
        m_el[c] = 0; m_sq[c] = 0; m_tk[c] = 0;
        if (w) begin m_sh[c] = int'(div_wdata); m_pend[c] = 1; end
      end else if (!en[c]) begin
        m_el[c] = 0; m_sq[c] = 0; m_tk[c] = 0;
        if (w) begin m_act[c] = int'(div_wdata); m_sh[c] = m_act[c]; m_pend[c] = 0; end
        else if (m_pend[c]) begin m_act[c] = m_sh[c]; m_pend[c] = 0; end
      end else begin
        fin = (m_el[c] == m_act[c]);
        m_el[c] = fin ? 0 : m_el[c] + 1;
        if (fin && w) begin m_act[c] = int'(div_wdata); m_sh[c] = m_act[c]; m_pend[c] = 0; end
        else if (fin && m_pend[c]) begin m_act[c] = m_sh[c]; m_pend[c] = 0; end
        else if (w) begin m_sh[c] = int'(div_wdata); m_pend[c] = 1; end
        m_tk[c] = mode[c] && fin;
        m_sq[c] = mode[c] ? 1'b0 : (m_sq[c] ^ fin);
      end
    end
    model_ok = 1'b1;
  end

  // Compare every channel output against the model on each falling edge.
  always @(negedge clk_in) begin
    if (model_ok) begin
      logic [N_CH-1:0] e_clk, e_tk, e_pd;
      for (int c = 0; c < N_CH; c++) begin
        e_clk[c] = m_sq[c]; e_tk[c] = m_tk[c]; e_pd[c] = m_pend[c];
      end
      check("model_clk_out", int'(clk_out), int'(e_clk));
      check("model_tick", int'(tick), int'(e_tk));
      check("model_pending", int'(pending), int'(e_pd));
    end
  end

  function automatic logic get_sig(input int which, input int ch);
    case (which)
      0: return clk_out[ch];
      1: return tick[ch];
      default: return pending[ch];
    endcase
  endfunction

  // Counts falling edges until the chosen signal equals val; -1 if it never does.
  task automatic wait_for(input int which, input int ch, input logic val, output int n);
    n = -1;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk_in);
      if (get_sig(which, ch) == val) begin n = k; break; end
    end
  endtask

  task automatic write_div(input int ch, input int d);
    div_wr = 1'b1; div_sel = SEL_W'(ch); div_wdata = CNT_W'(d);
    @(negedge clk_in);
    div_wr = 1'b0;
  endtask

  initial begin
    int n, f0, f1;
    rst = 1'b0;
    repeat (3) @(negedge clk_in);
    rst = 1'b1;
    @(negedge clk_in);
    check("reset_clk_out", int'(clk_out), 0);
    check("reset_tick", int'(tick), 0);
    check("reset_pending", int'(pending), 0);

    // Default divisor 49: rise 50 cycles after enable, 50/50 duty.
    en[0] = 1'b1;
    wait_for(0, 0, 1'b1, n); check("default_first_rise", n, 50);
    wait_for(0, 0, 1'b0, n); check("default_high", n, 50);
    wait_for(0, 0, 1'b1, n); check("default_low", n, 50);
    en[0] = 1'b0;

    // Strobe with D=3, then D=0.
    mode[1] = 1'b1;
    write_div(1, 3);
    en[1] = 1'b1;
    wait_for(1, 1, 1'b1, n); check("strobe_first", n, 4);
    @(negedge clk_in); check("strobe_width", int'(tick[1]), 0);
    wait_for(1, 1, 1'b1, n); check("strobe_period", n + 1, 4);
    write_div(1, 0);
    repeat (10) @(negedge clk_in);
    for (int k = 0; k < 5; k++) begin
      check("strobe_d0_high", int'(tick[1]), 1);
      @(negedge clk_in);
    end

    // Glitch-free update: D=9 running, write 4 mid-period.
    write_div(0, 9);
    en[0] = 1'b1;
    wait_for(0, 0, 1'b1, n); check("d9_first_rise", n, 10);
    repeat (4) @(negedge clk_in);
    write_div(0, 4);
    check("midperiod_pending", int'(pending[0]), 1);
    wait_for(0, 0, 1'b0, n); check("old_half_kept", n + 5, 10);
    check("pending_cleared", int'(pending[0]), 0);
    wait_for(0, 0, 1'b1, n); check("new_half_low", n, 5);
    wait_for(0, 0, 1'b0, n); check("new_half_high", n, 5);

    // Write landing exactly on the wrap edge.
    repeat (4) @(negedge clk_in);
    write_div(0, 6);
    check("wrap_write_toggled", int'(clk_out[0]), 1);
    check("wrap_write_no_pending", int'(pending[0]), 0);
    wait_for(0, 0, 1'b0, n); check("wrap_write_half", n, 7);

    // Last write wins.
    write_div(0, 7);
    write_div(0, 2);
    wait_for(0, 0, 1'b1, n);
    wait_for(0, 0, 1'b0, n); check("last_write_wins", n, 3);

    // Out-of-range select touches nothing.
    write_div(3, 1);
    check("bad_sel_pending", int'(pending), 0);

    // Sync alignment with D=2 and D=5 strobes.
    en = '0;
    @(negedge clk_in);
    write_div(0, 2);
    write_div(1, 5);
    mode = 3'b011; en = 3'b011;
    repeat (13) @(negedge clk_in);
    sync = 1'b1;
    @(negedge clk_in);
    sync = 1'b0;
    check("sync_tick", int'(tick), 0);
    check("sync_clk_out", int'(clk_out), 0);
    f0 = -1; f1 = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk_in);
      if (tick[0] && f0 < 0) f0 = k;
      if (tick[1] && f1 < 0) f1 = k;
    end
    check("sync_first_tick_ch0", f0, 3);
    check("sync_first_tick_ch1", f1, 6);

    // Disable with a pending write applies it; re-enable gives a full new period.
    wait_for(1, 0, 1'b1, n);
    write_div(0, 6);
    check("en_drop_pending_set", int'(pending[0]), 1);
    en[0] = 1'b0;
    @(negedge clk_in);
    check("en_drop_applied", int'(pending[0]), 0);
    en[0] = 1'b1;
    wait_for(1, 0, 1'b1, n); check("en_restart_period", n, 7);

    // Reset mid-operation with clk_out high and a write pending.
    en[2] = 1'b0; mode[2] = 1'b0;
    write_div(2, 3);
    en[2] = 1'b1;
    wait_for(0, 2, 1'b1, n); check("ch2_first_rise", n, 4);
    write_div(2, 1);
    check("ch2_pending", int'(pending[2]), 1);
    check("ch2_still_high", int'(clk_out[2]), 1);
    rst = 1'b0; en = 3'b001; mode = 3'b000;
    @(negedge clk_in);
    check("midrst_clk_out", int'(clk_out), 0);
    check("midrst_tick", int'(tick), 0);
    check("midrst_pending", int'(pending), 0);
    rst = 1'b1;
    wait_for(0, 0, 1'b1, n); check("midrst_default_div", n, 50);

    // Randomized traffic, checked by the model every cycle.
    en = '1;
    for (int k = 0; k < 4000; k++) begin
      @(negedge clk_in);
      for (int c = 0; c < N_CH; c++) begin
        if ($urandom_range(0, 99) < 3) en[c] = ~en[c];
        if ($urandom_range(0, 99) < 2) mode[c] = ~mode[c];
      end
      sync = ($urandom_range(0, 59) == 0);
      div_wr = ($urandom_range(0, 7) == 0);
      div_sel = SEL_W'($urandom_range(0, 3));
      div_wdata = CNT_W'($urandom_range(0, 7));
      rst = ($urandom_range(0, 499) != 0);
    end
    @(negedge clk_in);
    rst = 1'b1; sync = 1'b0; div_wr = 1'b0;
    repeat (5) @(negedge clk_in);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clk_div_multi.md
Name: clk_div_multi

Overview:
- Multi-channel programmable clock/strobe divider. Generalises the fixed-constant divider.
- Each channel has:
  - a runtime-writable divisor, double-buffered so updates land only at a period boundary;
  - a per-channel enable;
  - a mode select: square-wave clock or single-cycle tick strobe.
- Sits between the system clock and slow consumers: serial bit-rate timing, CPU step clock, LED/debug strobes.
- A global sync input phase-aligns all channels.

Parameters:
- N_CH, 2, number of independent divider channels (>=1).
- CNT_W, 16, width of divisor and per-channel counter.
- DEFAULT_DIV, 16'd49, active divisor loaded into every channel at reset (must fit CNT_W).

Ports:
- clk_in  in  1  system clock; all logic on posedge.
- rst  in  1  reset, synchronous, active-low.
- en  in  N_CH  per-channel run enable.
- mode  in  N_CH  per-channel mode; 0 = SQUARE, 1 = STROBE.
- sync  in  1  single-cycle pulse; restarts every channel's period.
- div_wr  in  1  divisor write strobe.
- div_sel  in  max(1,$clog2(N_CH))  channel addressed by div_wr.
- div_wdata  in  CNT_W  new divisor value D.
- clk_out  out  N_CH  divided square clock (SQUARE mode), else 0.
- tick  out  N_CH  one-cycle pulse at each period wrap (STROBE mode), else 0.
- pending  out  N_CH  shadow divisor written but not yet active.

Behaviour:
- Reset (rst==0 at posedge):
  - cnt = 0, active_div = DEFAULT_DIV, shadow = 0, pending = 0;
  - clk_out = 0, tick = 0 for all channels.
- Per-channel counter counts 0..active_div.
  - wrap = en && (cnt == active_div); on wrap, cnt <= 0, else cnt <= cnt+1.
- SQUARE mode:
  - clk_out toggles (registered) on each wrap; tick = 0.
  - Output period = 2*(D+1) clk_in cycles, duty 50%.
  - D = 0 gives clk_in/2.
- STROBE mode:
  - tick is registered and high for exactly the one cycle after each wrap; clk_out = 0.
  - Tick period = D+1 cycles. D = 0 gives tick high continuously.
- Outputs are registered. First tick, or first clk_out rising edge, appears D+1 cycles after en rises with cnt = 0.
- Divisor write (div_wr && div_sel == ch):
  - shadow <= div_wdata, pending <= 1.
  - div_sel >= N_CH: write ignored.
- Divisor update:
  - At the next wrap: active_div <= shadow, pending <= 0.
  - The period in progress completes with the old divisor; no runt or glitch.
  - Write in the same cycle as a wrap: the written value goes directly into active_div at that wrap; pending stays 0.
  - Second write before the wrap: overwrites shadow (last write wins).
- en low:
  - cnt held at 0, clk_out <= 0, tick <= 0.
  - If pending, shadow is applied immediately (active_div <= shadow, pending <= 0).
  - en rising restarts a full period.
- mode change while enabled: takes effect on the next cycle. Outputs of the now-unused mode are forced 0 the following cycle. Counter is not disturbed.
- sync:
  - All channels: cnt <= 0, clk_out <= 0, tick <= 0.
  - pending and shadow are untouched; pending is not applied by sync.
  - sync has priority over wrap in the same cycle. Reset has priority over everything.
- Reset asserted mid-operation: all state returns to reset values on that edge, regardless of en, sync or div_wr.
- Counter compare uses exact equality. active_div changes only at wrap or while disabled, so cnt never exceeds active_div.

Decomposition:
- Package clk_div_pkg:
  - typedef enum logic {MODE_SQUARE=1'b0, MODE_STROBE=1'b1} div_mode_t;
  - localparam default constants for CNT_W and DEFAULT_DIV.
- Sub-module div_chan holds:
  - one channel's counter, active/shadow divisor, pending flag and output registers;
  - inputs: en, mode, sync, wr (pre-decoded), wdata.
- clk_div_multi instantiates div_chan N_CH times via generate and decodes div_sel.

Test Plan:
- Reset value: rst=0 for 3 cycles, then 1 with en=0 -> clk_out=0, tick=0, pending=0 on all channels; active divisor reads back as 49 via behaviour (ch0 SQUARE, en=1 → first clk_out rise 50 cycles later, period 100).
- Strobe timing: ch1 STROBE, write D=3, en=1 -> tick high 1 cycle every 4 cycles. Write D=0 -> tick continuously high.
- Glitch-free update: ch0 SQUARE D=9 running, write D=4 mid-period (cnt=5) -> pending=1; current half-period still 10 cycles; subsequent half-periods 5 cycles; pending clears at the wrap.
- Boundary writes:
  - write landing exactly on the wrap cycle -> new D active immediately, pending never asserts;
  - two writes (7 then 2) before wrap -> D=2 used;
  - div_sel=N_CH -> no channel changes.
- Sync/enable:
  - two channels D=2 and D=5 free-running, pulse sync -> both restart from cnt=0 with outputs 0; next ticks at +3 and +6 cycles;
  - drop en with pending write -> divisor applied, restart on en=1 gives full new period.
- Reset mid-operation: assert rst while clk_out=1 and pending=1 -> next cycle all outputs 0, pending 0, divisor back to DEFAULT_DIV.
